store_buffer_fifo: RTL and testbench

Parametrised, in-order store buffer between the memory stage and the data cache. It accepts byte-masked stores, coalesces stores to the same word, forwards buffered bytes to loads, and drains entries oldest-first to the cache over a valid/ready handshake. Draining starts at a programmable occupancy threshold or on an explicit flush.

---
 rtl/store_buffer_fifo_if.sv | 52 +++++
 rtl/store_buffer_fifo.sv | 161 ++++++++++++++++
 tb/tb_store_buffer_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_fifo_if.sv
// Store-buffer port bundle: store, load-forward, drain and flush/status signals.
// The slave modport is the buffer; the master modport is the pipeline/cache side.
interface store_buffer_fifo_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic [BE_W-1:0]   st_be;

    logic              ld_valid;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_hit;
    logic              ld_full;
    logic [DATA_W-1:0] ld_data;
    logic [BE_W-1:0]   ld_be;

    logic              dr_valid;
    logic              dr_ready;
    logic [ADDR_W-1:0] dr_addr;
    logic [DATA_W-1:0] dr_data;
    logic [BE_W-1:0]   dr_be;

    logic              flush;
    logic              flush_done;
    logic [CNT_W-1:0]  count;
    logic              empty;

    modport slave (
        input  st_valid, st_addr, st_data, st_be,
        input  ld_valid, ld_addr,
        input  dr_ready, flush,
        output st_ready, ld_hit, ld_full, ld_data, ld_be,
        output dr_valid, dr_addr, dr_data, dr_be,
        output flush_done, count, empty
    );

    modport master (
        output st_valid, st_addr, st_data, st_be,
        output ld_valid, ld_addr,
        output dr_ready, flush,
        input  st_ready, ld_hit, ld_full, ld_data, ld_be,
        input  dr_valid, dr_addr, dr_data, dr_be,
        input  flush_done, count, empty
    );
endinterface

// File: rtl/store_buffer_fifo.sv
// In-order coalescing store buffer with byte-wise load forwarding and
// threshold/flush-triggered oldest-first draining to the data cache.
module store_buffer_fifo #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 4,
    parameter int DRAIN_THRESH = DEPTH
) (
    input  logic                clk,
    input  logic                rst,
    store_buffer_fifo_if.slave  sb
);
    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

    state_t            state;
    logic [ADDR_W-1:0] e_addr [DEPTH];
    logic [DATA_W-1:0] e_data [DEPTH];
    logic [BE_W-1:0]   e_be   [DEPTH];
    logic [DEPTH-1:0]  e_vld;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic              full;
    logic              is_empty;
    logic              dr_valid;
    logic              st_ready;
    logic              pop;
    logic              active;
    logic              alloc;
    logic              merge;
    logic              hit;
    logic [PTR_W-1:0]  hit_idx;
    logic [DATA_W-1:0] fwd_data;
    logic [BE_W-1:0]   fwd_be;

    function automatic logic [DATA_W-1:0] byte_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < BE_W; b++)
            m[b*8 +: 8] = {8{be[b]}};
        return m;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign is_empty = (count == '0);
    assign dr_valid = (state != IDLE) && !is_empty;
    assign pop      = dr_valid && sb.dr_ready;

    // The head is only a merge target before it has been offered to the cache.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_vld[i] && (e_addr[i] == sb.st_addr) &&
                !(dr_valid && (PTR_W'(i) == rd_ptr))) begin
                hit     = 1'b1;
                hit_idx = PTR_W'(i);
            end
        end
    end

    assign st_ready  = (state != FLUSH) && (!full || hit);
    assign active    = sb.st_valid && st_ready && (sb.st_be != '0);
    assign merge     = active && hit;
    assign alloc     = active && !hit;
    assign count_nxt = count + CNT_W'(alloc) - CNT_W'(pop);

    // Walk oldest to youngest so the youngest matching byte wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx      = '0;
        fwd_data = '0;
        fwd_be   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PTR_W'(i);
            if (e_vld[idx] && (e_addr[idx] == sb.ld_addr)) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (e_be[idx][b]) begin
                        fwd_be[b]          = 1'b1;
                        fwd_data[b*8 +: 8] = e_data[idx][b*8 +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            e_vld  <= '0;
        end else begin
            count <= count_nxt;
            if (pop) begin
                e_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (alloc) begin
                e_vld[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (sb.flush)
                        state <= FLUSH;
                    else if (count >= CNT_W'(DRAIN_THRESH))
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (pop || is_empty) begin
                        if (sb.flush)
                            state <= FLUSH;
                        else if (count_nxt < CNT_W'(DRAIN_THRESH))
                            state <= IDLE;
                    end
                end
                FLUSH: begin
                    if (is_empty)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Payload storage carries no reset; e_vld alone qualifies it.
    always_ff @(posedge clk) begin
        if (alloc) begin
            e_addr[wr_ptr] <= sb.st_addr;
            e_data[wr_ptr] <= sb.st_data & byte_mask(sb.st_be);
            e_be[wr_ptr]   <= sb.st_be;
        end
        if (merge) begin
            for (int b = 0; b < BE_W; b++)
                if (sb.st_be[b])
                    e_data[hit_idx][b*8 +: 8] <= sb.st_data[b*8 +: 8];
            e_be[hit_idx] <= e_be[hit_idx] | sb.st_be;
        end
    end

    assign sb.st_ready   = st_ready;
    assign sb.ld_be      = sb.ld_valid ? fwd_be : '0;
    assign sb.ld_data    = sb.ld_valid ? fwd_data : '0;
    assign sb.ld_hit     = sb.ld_valid && (fwd_be != '0);
    assign sb.ld_full    = sb.ld_valid && (&fwd_be);
    assign sb.dr_valid   = dr_valid;
    assign sb.dr_addr    = e_addr[rd_ptr];
    assign sb.dr_data    = e_data[rd_ptr];
    assign sb.dr_be      = e_be[rd_ptr];
    assign sb.flush_done = (state == FLUSH) && is_empty;
    assign sb.count      = count;
    assign sb.empty      = is_empty;
endmodule

// File: tb/tb_store_buffer_fifo.sv
// Store buffer bench: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the buffer.
module tb_store_buffer_fifo;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 4;
    localparam int THRESH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    store_buffer_fifo_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) sb ();

    store_buffer_fifo #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .DRAIN_THRESH(THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sb(sb)
    );

    ent_t q[$];
    int   mode;            // 0 idle, 1 threshold drain, 2 flush
    int   n_chk = 0;
    int   n_bad = 0;
    bit   e_dr_valid;
    bit   e_st_ready;
    int   e_hit_j;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask32(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++)
            if (be[b]) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check_model();
        logic [31:0] fd;
        logic [3:0]  fb;
        e_dr_valid = (mode != 0) && (q.size() != 0);
        e_hit_j = -1;
        foreach (q[j])
            if (q[j].addr == sb.st_addr && !(e_dr_valid && j == 0)) e_hit_j = j;
        e_st_ready = (mode != 2) && ((q.size() < DEPTH) || (e_hit_j >= 0));
        fd = '0;
        fb = '0;
        foreach (q[j])
            if (q[j].addr == sb.ld_addr)
                for (int b = 0; b < 4; b++)
                    if (q[j].be[b]) begin
                        fb[b] = 1'b1;
                        fd[b*8 +: 8] = q[j].data[b*8 +: 8];
                    end
        if (!sb.ld_valid) begin
            fd = '0;
            fb = '0;
        end
        chk("count", 64'(sb.count), 64'(q.size()));
        chk("empty", 64'(sb.empty), 64'(q.size() == 0));
        chk("st_ready", 64'(sb.st_ready), 64'(e_st_ready));
        chk("dr_valid", 64'(sb.dr_valid), 64'(e_dr_valid));
        chk("flush_done", 64'(sb.flush_done), 64'((mode == 2) && (q.size() == 0)));
        chk("ld_be", 64'(sb.ld_be), 64'(fb));
        chk("ld_data", 64'(sb.ld_data), 64'(fd));
        chk("ld_hit", 64'(sb.ld_hit), 64'(fb != 0));
        chk("ld_full", 64'(sb.ld_full), 64'(fb == 4'hF));
        if (e_dr_valid) begin
            chk("dr_addr", 64'(sb.dr_addr), 64'(q[0].addr));
            chk("dr_be", 64'(sb.dr_be), 64'(q[0].be));
            chk("dr_data", 64'(sb.dr_data & mask32(q[0].be)), 64'(q[0].data));
        end
    endtask

    task automatic model_tick();
        int   n_pre;
        bit   pop;
        bit   active;
        ent_t e;
        n_pre  = q.size();
        pop    = e_dr_valid && sb.dr_ready;
        active = sb.st_valid && e_st_ready && (sb.st_be != 0);
        if (active) begin
            if (e_hit_j >= 0) begin
                e = q[e_hit_j];
                for (int b = 0; b < 4; b++)
                    if (sb.st_be[b]) e.data[b*8 +: 8] = sb.st_data[b*8 +: 8];
                e.be = e.be | sb.st_be;
                q[e_hit_j] = e;
            end else begin
                e.addr = sb.st_addr;
                e.data = sb.st_data & mask32(sb.st_be);
                e.be   = sb.st_be;
                q.push_back(e);
            end
        end
        if (pop) void'(q.pop_front());
        case (mode)
            0: if (sb.flush) mode = 2; else if (n_pre >= THRESH) mode = 1;
            1: if (pop || n_pre == 0) begin
                   if (sb.flush) mode = 2;
                   else if (q.size() < THRESH) mode = 0;
               end
            default: if (n_pre == 0) mode = 0;
        endcase
    endtask

    task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic [3:0] sbe, input logic lv, input logic [31:0] la,
                         input logic dr, input logic fl);
        @(negedge clk);
        sb.st_valid = sv;
        sb.st_addr  = sa;
        sb.st_data  = sd;
        sb.st_be    = sbe;
        sb.ld_valid = lv;
        sb.ld_addr  = la;
        sb.dr_ready = dr;
        sb.flush    = fl;
        #1;
        check_model();
    endtask

    task automatic tick();
        @(posedge clk);
        model_tick();
    endtask

    task automatic cyc(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [3:0] sbe, input logic dr, input logic fl);
        drive(sv, sa, sd, sbe, 1'b0, 32'h0, dr, fl);
        tick();
    endtask

    task automatic drain_all();
        repeat (8) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        repeat (2) cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic idle_inputs();
        sb.st_valid = 1'b0;
        sb.st_addr  = '0;
        sb.st_data  = '0;
        sb.st_be    = '0;
        sb.ld_valid = 1'b0;
        sb.ld_addr  = '0;
        sb.dr_ready = 1'b0;
        sb.flush    = 1'b0;
    endtask

    initial begin
        mode = 0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 64'(sb.count), 64'd0);
        chk("rst_empty", 64'(sb.empty), 64'd1);
        chk("rst_st_ready", 64'(sb.st_ready), 64'd1);
        chk("rst_dr_valid", 64'(sb.dr_valid), 64'd0);
        chk("rst_flush_done", 64'(sb.flush_done), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Fill and drain: threshold starts the drain, flush carries it to empty.
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'hA0 + 32'(i), 32'h1000 + 32'(i), 4'hF, 1'b0, 1'b0);
        drive(1'b1, 32'hA4, 32'h5555, 4'hF, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fd_count", 64'(sb.count), 64'd4);
        chk("fd_blocked", 64'(sb.st_ready), 64'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("fd_dv", 64'(sb.dr_valid), 64'd1);
        chk("fd_beat0", 64'(sb.dr_addr), 64'hA0);
        tick();
        for (int i = 1; i < 4; i++) begin
            drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
            chk("fd_beat", 64'(sb.dr_addr), 64'hA0 + 64'(i));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fd_empty", 64'(sb.empty), 64'd1);
        tick();

        // Coalescing, including a merge into a non-head entry of a full buffer.
        cyc(1'b1, 32'h10, 32'h000000AA, 4'h1, 1'b0, 1'b0);
        cyc(1'b1, 32'h10, 32'hBB000000, 4'h8, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h10, 1'b0, 1'b0);
        chk("co_count", 64'(sb.count), 64'd1);
        chk("co_data", 64'(sb.ld_data), 64'hBB0000AA);
        chk("co_be", 64'(sb.ld_be), 64'h9);
        tick();
        for (int i = 1; i < 4; i++)
            cyc(1'b1, 32'h10 + 32'(i), 32'h0, 4'hF, 1'b0, 1'b0);
        drive(1'b1, 32'h12, 32'hCAFE0000, 4'hC, 1'b1, 32'h12, 1'b0, 1'b0);
        chk("co_full_merge", 64'(sb.st_ready), 64'd1);
        tick();
        drive(1'b1, 32'h30, 32'h1, 4'hF, 1'b1, 32'h12, 1'b0, 1'b0);
        chk("co_full_new", 64'(sb.st_ready), 64'd0);
        chk("co_merged", 64'(sb.ld_data), 64'hCAFE0000);
        tick();
        drain_all();

        // Forwarding.
        cyc(1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 32'h00005500, 4'h2, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h20, 1'b0, 1'b0);
        chk("fw_data", 64'(sb.ld_data), 64'h11225544);
        chk("fw_full", 64'(sb.ld_full), 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h24, 1'b0, 1'b0);
        chk("fw_miss", 64'(sb.ld_hit), 64'd0);
        tick();
        drain_all();

        // Flush with two entries below threshold.
        cyc(1'b1, 32'h60, 32'h6, 4'hF, 1'b0, 1'b0);
        cyc(1'b1, 32'h61, 32'h7, 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1);
        drive(1'b1, 32'h62, 32'h8, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("fl_block0", 64'(sb.st_ready), 64'd0);
        chk("fl_beat0", 64'(sb.dr_addr), 64'h60);
        tick();
        drive(1'b1, 32'h62, 32'h8, 4'hF, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("fl_block1", 64'(sb.st_ready), 64'd0);
        chk("fl_beat1", 64'(sb.dr_addr), 64'h61);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b1);
        chk("fl_done", 64'(sb.flush_done), 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        chk("fl_done_once", 64'(sb.flush_done), 64'd0);
        tick();

        // Flush on an empty buffer.
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        chk("fe_done", 64'(sb.flush_done), 64'd1);
        tick();

        // Randomised traffic with backpressure, flushes and zero-mask stores.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 9) < 7, 32'h40 + 32'($urandom_range(0, 5)), $urandom,
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  32'h40 + 32'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 15) == 0);
            tick();
        end

        // Reset while a drain beat is being offered.
        drain_all();
        for (int i = 0; i < 4; i++)
            cyc(1'b1, 32'h50 + 32'(i), 32'h9 + 32'(i), 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h51, 1'b0, 1'b0);
        chk("rm_dv_before", 64'(sb.dr_valid), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("rm_count", 64'(sb.count), 64'd0);
        chk("rm_empty", 64'(sb.empty), 64'd1);
        chk("rm_st_ready", 64'(sb.st_ready), 64'd1);
        chk("rm_dr_valid", 64'(sb.dr_valid), 64'd0);
        chk("rm_flush_done", 64'(sb.flush_done), 64'd0);
        chk("rm_ld_hit", 64'(sb.ld_hit), 64'd0);
        chk("rm_ld_data", 64'(sb.ld_data), 64'd0);
        idle_inputs();
        q.delete();
        mode = 0;
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b1, 32'h70, 32'h12345678, 4'hF, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
